// File: rtl/shell_ctrl_regs.sv
// ============================================================================
//  Module      : shell_ctrl_regs
//  Description : AXI4-Lite control/status register bank for the shell.
//                Provides shell ID/capabilities, per-channel enables, a timed
//                role soft-reset generator and a maskable per-channel
//                interrupt aggregator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shell_ctrl_regs #(
   parameter int          CHANNEL    = 4,
   parameter int          ADDR_WIDTH = 12,
   parameter int          RST_CYCLES = 16,
   parameter logic [31:0] SHELL_ID   = 32'h5AED_0001
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [31:0]           s_axil_wdata,
   input  logic [3:0]            s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [31:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  role_rst,
   output logic [CHANNEL-1:0]    ch_en,
   input  logic [CHANNEL-1:0]    role_irq,
   output logic                  irq
);

   localparam int         CNT_W    = $clog2(RST_CYCLES + 1);
   localparam logic [1:0] C_OKAY   = 2'b00;
   localparam logic [1:0] C_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wstate_e;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rstate_e;

   wstate_e             wstate_q;
   rstate_e             rstate_q;
   logic                awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]          bresp_q, rresp_q;
   logic [31:0]         rdata_q;

   logic [31:0]         scratch_q, scratch_d;
   logic                gie_q, gie_d;
   logic [CHANNEL-1:0]  chen_q, chen_d;
   logic [CHANNEL-1:0]  stat_q, stat_d;
   logic [CHANNEL-1:0]  mask_q, mask_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                irq_q, irq_d;

   logic                w_wr_hit, w_rd_hit, w_wr_en;
   logic [2:0]          w_wr_idx, w_rd_idx;
   logic [7:0]          w_sel;
   logic [31:0]         w_wmask;
   logic [31:0]         w_rdata;
   logic                w_unused_addr;

   // Byte-lane bits [1:0] do not take part in decoding
   assign w_unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

   assign w_wr_idx = s_axil_awaddr[4:2];
   assign w_rd_idx = s_axil_araddr[4:2];

   // Only the lowest 32 bytes are mapped; everything above decodes as DECERR
   generate
      if (ADDR_WIDTH > 5) begin : g_hi_dec
         assign w_wr_hit = ~|s_axil_awaddr[ADDR_WIDTH-1:5];
         assign w_rd_hit = ~|s_axil_araddr[ADDR_WIDTH-1:5];
      end else begin : g_no_hi_dec
         assign w_wr_hit = 1'b1;
         assign w_rd_hit = 1'b1;
      end
   endgenerate

   assign w_wr_en = (wstate_q == W_ACK);
   assign w_sel   = (w_wr_en && w_wr_hit) ? (8'd1 << w_wr_idx) : 8'd0;
   assign w_wmask = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                     {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};

   // Next-state for the register file, soft-reset counter and interrupt logic
   always_comb begin
      scratch_d = scratch_q;
      gie_d     = gie_q;
      chen_d    = chen_q;
      mask_d    = mask_q;
      stat_d    = stat_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      irq_d     = gie_q & (|(stat_q & mask_q));
      if (w_sel[2]) begin
         scratch_d = (scratch_q & ~w_wmask) | (s_axil_wdata & w_wmask);
      end
      if (w_sel[3] && s_axil_wstrb[0]) begin
         gie_d = s_axil_wdata[1];
         if (s_axil_wdata[0]) begin
            cnt_d = CNT_W'(RST_CYCLES);
         end
      end
      for (int i = 0; i < CHANNEL; i++) begin
         if (w_sel[4] && w_wmask[i]) chen_d[i] = s_axil_wdata[i];
         if (w_sel[6] && w_wmask[i]) mask_d[i] = s_axil_wdata[i];
         if (w_sel[5] && w_wmask[i] && s_axil_wdata[i]) stat_d[i] = 1'b0;
         // A new request in the same cycle as a clear keeps the bit set
         if (role_irq[i]) stat_d[i] = 1'b1;
      end
   end

   // Register file state; the counter restarts its full count on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch_q <= '0;
         gie_q     <= 1'b0;
         chen_q    <= '0;
         mask_q    <= '0;
         stat_q    <= '0;
         cnt_q     <= CNT_W'(RST_CYCLES);
         irq_q     <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         gie_q     <= gie_d;
         chen_q    <= chen_d;
         mask_q    <= mask_d;
         stat_q    <= stat_d;
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
      end
   end

   // Read data multiplexer
   always_comb begin
      w_rdata = '0;
      case (w_rd_idx)
         3'd0:    w_rdata = SHELL_ID;
         3'd1:    w_rdata = {24'd0, 8'(CHANNEL)};
         3'd2:    w_rdata = scratch_q;
         3'd3:    w_rdata = {30'd0, gie_q, 1'b0};
         3'd4:    w_rdata = 32'(chen_q);
         3'd5:    w_rdata = 32'(stat_q);
         3'd6:    w_rdata = 32'(mask_q);
         default: w_rdata = {31'd0, role_rst};
      endcase
      if (!w_rd_hit) w_rdata = '0;
   end

   // Write channel FSM: waits for address and data together, one-cycle ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= C_OKAY;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (s_axil_awvalid && s_axil_wvalid) begin
                  wstate_q  <= W_ACK;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_ACK: begin
               wstate_q  <= W_RESP;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b1;
               bresp_q   <= w_wr_hit ? C_OKAY : C_DECERR;
            end
            W_RESP: begin
               if (s_axil_bready) begin
                  wstate_q <= W_IDLE;
                  bvalid_q <= 1'b0;
               end
            end
            default: begin
               wstate_q  <= W_IDLE;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read channel FSM: one-cycle address ack, data held until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= C_OKAY;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (s_axil_arvalid) begin
                  rstate_q  <= R_ACK;
                  arready_q <= 1'b1;
               end
            end
            R_ACK: begin
               rstate_q  <= R_DATA;
               arready_q <= 1'b0;
               rvalid_q  <= 1'b1;
               rdata_q   <= w_rdata;
               rresp_q   <= w_rd_hit ? C_OKAY : C_DECERR;
            end
            R_DATA: begin
               if (s_axil_rready) begin
                  rstate_q <= R_IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            default: begin
               rstate_q  <= R_IDLE;
               arready_q <= 1'b0;
               rvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_arready = arready_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;
   assign role_rst       = (cnt_q != '0);
   assign ch_en          = chen_q;
   assign irq            = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_shell_ctrl_regs.sv
// ============================================================================
//  Module      : tb_shell_ctrl_regs
//  Description : Directed self-checking bench for shell_ctrl_regs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shell_ctrl_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] s_axil_awaddr;
   logic        s_axil_awvalid;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata;
   logic [3:0]  s_axil_wstrb;
   logic        s_axil_wvalid;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready;
   logic [11:0] s_axil_araddr;
   logic        s_axil_arvalid;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready;
   logic        role_rst;
   logic [3:0]  ch_en;
   logic [3:0]  role_irq;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   // Edge monitor counters
   int cyc      = 0;
   int aw_cnt   = 0;
   int aw_ne_w  = 0;
   int rr_cnt   = 0;
   int hs_cyc   = 0;

   shell_ctrl_regs #(
      .CHANNEL    (4),
      .ADDR_WIDTH (12),
      .RST_CYCLES (16),
      .SHELL_ID   (32'h5AED_0001)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .role_rst       (role_rst),
      .ch_en          (ch_en),
      .role_irq       (role_irq),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (s_axil_awready) begin
         aw_cnt <= aw_cnt + 1;
         hs_cyc <= cyc;
      end
      if (s_axil_awready !== s_axil_wready) aw_ne_w <= aw_ne_w + 1;
      if (role_rst) rr_cnt <= rr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $error("FAIL %s: observed=timeout expected=handshake", tag);
   endtask

   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      s_axil_awaddr  = addr;
      s_axil_wdata   = data;
      s_axil_wstrb   = strb;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      n = 0;
      while (!s_axil_awready && n < 20) begin tick(); n++; end
      if (!s_axil_awready) timeout("wr_awready");
      tick();
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      n = 0;
      while (!s_axil_bvalid && n < 20) begin tick(); n++; end
      if (!s_axil_bvalid) timeout("wr_bvalid");
      resp = s_axil_bresp;
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      s_axil_araddr  = addr;
      s_axil_arvalid = 1'b1;
      n = 0;
      while (!s_axil_arready && n < 20) begin tick(); n++; end
      if (!s_axil_arready) timeout("rd_arready");
      tick();
      s_axil_arvalid = 1'b0;
      n = 0;
      while (!s_axil_rvalid && n < 20) begin tick(); n++; end
      if (!s_axil_rvalid) timeout("rd_rvalid");
      data = s_axil_rdata;
      resp = s_axil_rresp;
      s_axil_rready = 1'b1;
      tick();
      s_axil_rready = 1'b0;
   endtask

   task automatic wait_rr_low();
      int n;
      n = 0;
      while (role_rst && n < 100) begin tick(); n++; end
      if (role_rst) timeout("role_rst_low");
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [1:0]  br;
      int          n;
      int          a0;
      int          r0;
      int          h1;

      rst = 1'b1;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0;
      s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
      role_irq = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_awready", {31'd0, s_axil_awready}, 32'd0);
      chk("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
      chk("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
      chk("rst_rdata",   s_axil_rdata,            32'd0);
      chk("rst_ch_en",   {28'd0, ch_en},          32'd0);
      chk("rst_irq",     {31'd0, irq},            32'd0);
      chk("rst_role_rst",{31'd0, role_rst},       32'd1);

      // Role reset stays up 16 cycles after rst falls
      rst = 1'b0;
      n = 0;
      while (role_rst && n < 100) begin n++; tick(); end
      chk("role_rst_len", n, 32'd16);

      axi_read(12'h000, rd, rr);
      chk("id_data", rd, 32'h5AED_0001);
      chk("id_resp", {30'd0, rr}, 32'd0);
      axi_read(12'h004, rd, rr);
      chk("cap_data", rd, 32'h0000_0004);
      axi_read(12'h008, rd, rr);
      chk("scratch_rst", rd, 32'd0);

      // Address leads data by 3 cycles; one handshake with aw/w together
      a0 = aw_cnt;
      s_axil_awaddr  = 12'h008;
      s_axil_awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("aw_lone_wait", {31'd0, s_axil_awready}, 32'd0);
      end
      axi_write(12'h008, 32'hDEAD_BEEF, 4'b0011, br);
      chk("scratch_bresp", {30'd0, br}, 32'd0);
      chk("aw_pulse_once", aw_cnt - a0, 32'd1);
      chk("aw_w_together", aw_ne_w, 32'd0);
      axi_read(12'h008, rd, rr);
      chk("scratch_strb_lo", rd, 32'h0000_BEEF);
      axi_write(12'h008, 32'hCAFE_0000, 4'b1100, br);
      axi_read(12'h008, rd, rr);
      chk("scratch_strb_hi", rd, 32'hCAFE_BEEF);

      // Soft reset pulse length
      r0 = rr_cnt;
      axi_write(12'h00C, 32'h1, 4'hF, br);
      wait_rr_low();
      chk("srst_len", rr_cnt - r0, 32'd16);
      axi_read(12'h00C, rd, rr);
      chk("ctrl_srst_reads0", rd, 32'd0);

      // Re-trigger 10 cycles after the first write extends the pulse
      r0 = rr_cnt;
      axi_write(12'h00C, 32'h1, 4'hF, br);
      h1 = hs_cyc;
      repeat (7) tick();
      chk("srst_active_mid", {31'd0, role_rst}, 32'd1);
      axi_write(12'h00C, 32'h1, 4'hF, br);
      chk("srst_gap", hs_cyc - h1, 32'd10);
      axi_read(12'h01C, rd, rr);
      chk("status_role_rst", rd, 32'd1);
      wait_rr_low();
      chk("srst_extended_len", rr_cnt - r0, 32'd26);
      axi_read(12'h01C, rd, rr);
      chk("status_idle", rd, 32'd0);

      // Interrupts
      axi_write(12'h018, 32'h4, 4'hF, br);
      axi_write(12'h00C, 32'h2, 4'hF, br);
      axi_read(12'h00C, rd, rr);
      chk("ctrl_gie", rd, 32'd2);
      role_irq = 4'b0100;
      tick();
      role_irq = 4'b0000;
      chk("irq_latency_0", {31'd0, irq}, 32'd0);
      tick();
      chk("irq_set", {31'd0, irq}, 32'd1);
      axi_read(12'h014, rd, rr);
      chk("irq_stat_set", rd, 32'd4);
      axi_write(12'h014, 32'h4, 4'hF, br);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      axi_read(12'h014, rd, rr);
      chk("irq_stat_clr", rd, 32'd0);
      role_irq = 4'b0100;
      tick(); tick();
      chk("irq_held_set", {31'd0, irq}, 32'd1);
      axi_write(12'h014, 32'h4, 4'hF, br);
      chk("irq_set_wins", {31'd0, irq}, 32'd1);
      axi_read(12'h014, rd, rr);
      chk("irq_stat_kept", rd, 32'd4);
      role_irq = 4'b0000;
      axi_write(12'h014, 32'h4, 4'hF, br);
      chk("irq_clr_after_drop", {31'd0, irq}, 32'd0);
      role_irq = 4'b0001;
      tick();
      role_irq = 4'b0000;
      tick(); tick();
      chk("irq_masked", {31'd0, irq}, 32'd0);
      axi_read(12'h014, rd, rr);
      chk("irq_stat_masked_bit", rd, 32'd1);

      // bvalid held while bready low, second write stalls
      a0 = aw_cnt;
      s_axil_awaddr  = 12'h008;
      s_axil_wdata   = 32'h1111_2222;
      s_axil_wstrb   = 4'hF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      n = 0;
      while (!s_axil_awready && n < 20) begin tick(); n++; end
      tick();
      s_axil_wdata = 32'h3333_4444;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bvalid_held", {31'd0, s_axil_bvalid}, 32'd1);
      end
      chk("no_second_awready", aw_cnt - a0, 32'd1);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;
      axi_write(12'h008, 32'h3333_4444, 4'hF, br);
      chk("second_write_once", aw_cnt - a0, 32'd2);
      axi_read(12'h008, rd, rr);
      chk("second_write_data", rd, 32'h3333_4444);

      // Unmapped and read-only targets
      axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, br);
      chk("unmapped_bresp", {30'd0, br}, 32'd3);
      axi_read(12'h040, rd, rr);
      chk("unmapped_rdata", rd, 32'd0);
      chk("unmapped_rresp", {30'd0, rr}, 32'd3);
      axi_write(12'h048, 32'h0BAD_0BAD, 4'hF, br);
      chk("alias_bresp", {30'd0, br}, 32'd3);
      axi_read(12'h008, rd, rr);
      chk("alias_no_effect", rd, 32'h3333_4444);
      axi_write(12'h000, 32'h1234_5678, 4'hF, br);
      chk("ro_bresp", {30'd0, br}, 32'd0);
      axi_read(12'h000, rd, rr);
      chk("ro_unchanged", rd, 32'h5AED_0001);

      // Reset in the middle of a write and a read
      axi_write(12'h010, 32'hF, 4'hF, br);
      chk("ch_en_set", {28'd0, ch_en}, 32'hF);
      s_axil_awaddr  = 12'h008;
      s_axil_wdata   = 32'h0;
      s_axil_wstrb   = 4'hF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      s_axil_araddr  = 12'h010;
      s_axil_arvalid = 1'b1;
      tick(); tick();
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      s_axil_arvalid = 1'b0;
      chk("mid_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
      chk("mid_rvalid", {31'd0, s_axil_rvalid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
      chk("async_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
      chk("async_ch_en",  {28'd0, ch_en},         32'd0);
      chk("async_role_rst", {31'd0, role_rst},    32'd1);
      tick();
      rst = 1'b0;
      wait_rr_low();
      axi_read(12'h010, rd, rr);
      chk("ch_en_after_rst", rd, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/shell_ctrl_regs.md
Name: shell_ctrl_regs

Overview:
Parametrised AXI4-Lite control/status register bank for the shell, sitting between the PS general-purpose master port and the role. It generalises the fixed single-role hookup to CHANNEL role channels. It provides shell identification, per-channel enables, a timed role soft-reset generator, and a maskable per-channel interrupt aggregator.

Parameters:
CHANNEL, 4, number of role channels (1..32)
ADDR_WIDTH, 12, AXI-Lite byte address width (min 5)
RST_CYCLES, 16, role soft-reset pulse length in clk cycles (>=1)
SHELL_ID, 32'h5AED_0001, value of the ID register

Ports:
clk  in  1  single clock for everything
rst  in  1  asynchronous, active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  ; s_axil_awready  out  1
s_axil_wdata  in  32  ; s_axil_wstrb  in  4  ; s_axil_wvalid  in  1  ; s_axil_wready  out  1
s_axil_bresp  out  2  ; s_axil_bvalid  out  1  ; s_axil_bready  in  1
s_axil_araddr  in  ADDR_WIDTH  ; s_axil_arvalid  in  1  ; s_axil_arready  out  1
s_axil_rdata  out  32  ; s_axil_rresp  out  2  ; s_axil_rvalid  out  1  ; s_axil_rready  in  1
role_rst  out  1  active-high role reset
ch_en  out  CHANNEL  per-channel enable
role_irq  in  CHANNEL  level interrupt requests from role
irq  out  1  aggregated interrupt to PS

Behaviour:
Reset values:
- All ready/valid outputs 0; bresp/rresp 0; rdata 0; ch_en 0; irq 0.
- role_rst is 1 while rst is high, and stays 1 for RST_CYCLES cycles after rst deasserts.

Register map (byte address; address bits [1:0] ignored; all other addresses unmapped):
- 0x00 ID: RO, SHELL_ID.
- 0x04 CAP: RO, [7:0]=CHANNEL, [31:8]=0.
- 0x08 SCRATCH: RW, reset 0.
- 0x0C CTRL: [0] SRST, write-1 starts soft reset, reads 0. [1] GIE, RW, reset 0.
- 0x10 CH_EN: RW, bits [CHANNEL-1:0], drives ch_en directly.
- 0x14 IRQ_STAT: W1C.
- 0x18 IRQ_MASK: RW, reset 0.
- 0x1C STATUS: RO, [0]=role_rst.
- Unimplemented bits read 0. RW registers honour wstrb per byte.
- Unmapped address: write has no effect and bresp=2'b11 (DECERR); read returns rdata=0, rresp=2'b11. Mapped accesses return 2'b00, including writes to RO registers, which are ignored.

Write FSM (W_IDLE -> W_ACK -> W_RESP):
- W_IDLE: when awvalid and wvalid are both high, go to W_ACK. A lone awvalid or lone wvalid waits.
- W_ACK: awready=wready=1 for exactly this cycle. The register update takes effect at the end of the cycle. Go to W_RESP.
- W_RESP: bvalid=1 and bresp stable until bready is sampled high, then W_IDLE. No new write is accepted while bvalid=1.

Read FSM (R_IDLE -> R_ACK -> R_DATA):
- R_IDLE: when arvalid is high, go to R_ACK.
- R_ACK: arready=1 for one cycle; rdata/rresp are registered at the end of the cycle.
- R_DATA: rvalid=1 with rdata stable until rready, then R_IDLE.
- Read and write FSMs are independent and may run concurrently.

Soft reset:
- An SRST write loads the counter with RST_CYCLES. role_rst=1 from the next cycle while counter != 0; the counter decrements each cycle.
- A new SRST write while active reloads the counter (extends the pulse).
- Register contents are not cleared by soft reset.

Interrupts:
- Each cycle, IRQ_STAT[i] |= role_irq[i].
- A W1C write clears bit i only if role_irq[i]=0 in that cycle; if set and clear coincide, set wins.
- irq is registered: irq = GIE & |(IRQ_STAT & IRQ_MASK), one cycle after the state change.

rst asserted mid-transaction: both FSMs return to idle at once and all outputs take their reset values; the in-flight transaction is dropped.

Test Plan:
1. After reset: read 0x00 -> 32'h5AED_0001, rresp=0; read 0x04 -> 32'h0000_0004; role_rst=1 for 16 cycles after rst falls, then 0.
2. Write 0x08=32'hDEAD_BEEF with wstrb=4'b0011, then read 0x08 -> 32'h0000_BEEF. awvalid asserted 3 cycles before wvalid -> awready/wready pulse together, once.
3. Write 0x0C=32'h1 -> role_rst high exactly 16 cycles. Rewrite at cycle 10 -> role_rst stays high until 16 cycles after the second write.
4. IRQ_MASK=4'b0100, GIE=1, pulse role_irq[2] for 1 cycle -> irq=1 one cycle later. Write 0x14=4'b0100 -> irq=0. Repeat with role_irq[2] held high during the W1C -> bit remains set, irq stays 1.
5. Hold bready low 5 cycles after a write -> bvalid held, no second awready. Write and read 0x40 -> bresp=2'b11, rdata=0, rresp=2'b11.
6. Assert rst while rvalid=1 and bvalid=1 -> both drop immediately; ch_en=0; a subsequent read of 0x10 returns 0.
